branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
Sequences the front end after the branch compare unit resolves a branch or jump in execute. Uses static not-taken prediction: any taken branch or any jump is a mispredict. On a mispredict it latches the target, presents it to fetch on a valid/ready redirect handshake, and then holds a pipeline flush for a programmable number of cycles. It also keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
ADDR_WIDTH, 32, width of PC and target addresses
FLUSH_CYCLES, 2, flush cycles after the redirect handshake completes (0 allowed)
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears all state
system_stall  input  1  global stall; freezes the FSM and counters
br_valid  input  1  branch/jump resolution valid this cycle
br_is_jump  input  1  resolved uop is JAL/JALR
br_taken  input  1  conditional branch taken (from branch compare unit)
br_target  input  ADDR_WIDTH  resolved next PC (from branch compare unit)
redirect_ready  input  1  fetch accepts the redirect
redirect_valid  output  1  redirect request to fetch
redirect_pc  output  ADDR_WIDTH  redirect target, bit0 forced to 0
flush  output  1  squash younger in-flight uops
ctrl_stall  output  1  hold issue/decode while not IDLE
branch_cnt  output  CNT_WIDTH  accepted branch/jump count, saturating
mispredict_cnt  output  CNT_WIDTH  mispredict count, saturating

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; redirect_pc=0; flush counter=0; both counters=0. All outputs read 0 in the cycle after reset.
- States: IDLE, REDIRECT, FLUSH.
- Accept condition: state==IDLE & br_valid & !system_stall.
  - On accept, branch_cnt increments by 1 and saturates at all-ones.
  - mispredict = br_is_jump | br_taken.
  - Accept with mispredict: redirect_pc <= {br_target[ADDR_WIDTH-1:1],1'b0}; mispredict_cnt increments (saturating); next state REDIRECT.
  - Accept without mispredict: stay IDLE; outputs unchanged.
- br_valid while not IDLE: ignored, since it is wrong-path. Not counted, no effect.
- REDIRECT:
  - redirect_valid=1, flush=1, ctrl_stall=1.
  - redirect_pc is held stable until the handshake.
  - Handshake completes at an edge where redirect_valid & redirect_ready & !system_stall.
  - After the handshake: if FLUSH_CYCLES==0, go to IDLE; otherwise go to FLUSH and load the counter with FLUSH_CYCLES-1.
- FLUSH:
  - redirect_valid=0, flush=1, ctrl_stall=1.
  - Counter decrements each non-stalled cycle. Leave for IDLE at the edge where the counter==0.
  - FLUSH therefore lasts exactly FLUSH_CYCLES non-stalled cycles.
- IDLE outputs: redirect_valid=0, flush=0, ctrl_stall=0.
- Output timing: all outputs are registered or decoded from registered state only, with no combinational path from inputs to outputs. The first REDIRECT cycle is the cycle after accept.
- system_stall=1: no state, counter, or perf-counter update. Outputs hold their current values. redirect_ready is ignored for the handshake.
- Reset mid-operation: reset overrides everything. The FSM goes straight to IDLE and the counters clear; no pending redirect survives.
- Width rule: counters are unsigned and saturate; they never wrap.

Test Plan:
1. Not-taken branch: br_valid=1, br_taken=0, br_is_jump=0 for 1 cycle -> branch_cnt=1, mispredict_cnt=0, redirect_valid and flush stay 0.
2. Taken branch, immediate accept: br_taken=1, br_target=0x0000_0100, redirect_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x100, flush=1. Then with FLUSH_CYCLES=2, flush=1 for 2 more cycles, then IDLE. mispredict_cnt=1.
3. Fetch backpressure on JALR: br_is_jump=1, br_target=0x0000_0203, redirect_ready=0 for 4 cycles then 1 -> redirect_pc=0x202 stable for 5 cycles, ctrl_stall=1 throughout. Additional br_valid pulses during this window leave branch_cnt unchanged.
4. system_stall=1 for 3 cycles while in FLUSH with the counter at 1 -> flush stays 1 and the counter does not decrement. IDLE is reached 2 cycles after the stall drops.
5. reset=0 asserted while in REDIRECT -> next cycle redirect_valid=0, flush=0, ctrl_stall=0, branch_cnt=0, mispredict_cnt=0.
6. Saturation with CNT_WIDTH=4: 17 accepted taken jumps -> branch_cnt=15 and mispredict_cnt=15, no wrap.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// branch_redirect_ctrl : redirects fetch after a mispredicted branch or jump
// (static not-taken prediction), holds a flush, and counts branch events.
// Revision: 1.0
// ============================================================================
module branch_redirect_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  system_stall,
  input  logic                  br_valid,
  input  logic                  br_is_jump,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  redirect_ready,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  ctrl_stall,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] c_FLUSH_LOAD =
    (FLUSH_CYCLES > 0) ? FCW'(FLUSH_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [FCW-1:0]        r_fcnt;
  logic [CNT_WIDTH-1:0]  r_bcnt;
  logic [CNT_WIDTH-1:0]  r_mcnt;
  logic                  w_accept;
  logic                  w_mispredict;
  logic                  w_handshake;
  logic                  w_fcnt_dec;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_handshake  = 1'b0;
    w_fcnt_dec   = 1'b0;
    w_mispredict = br_is_jump | br_taken;
    if (!system_stall) begin
      case (r_state)
        S_IDLE: begin
          if (br_valid) begin
            w_accept = 1'b1;
            if (w_mispredict) w_next_state = S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            w_handshake  = 1'b1;
            w_next_state = (FLUSH_CYCLES == 0) ? S_IDLE : S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == '0) w_next_state = S_IDLE;
          else              w_fcnt_dec   = 1'b1;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_fcnt  <= '0;
      r_bcnt  <= '0;
      r_mcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept && (r_bcnt != '1)) r_bcnt <= r_bcnt + 1'b1;
      if (w_accept && w_mispredict) begin
        r_pc <= {br_target[ADDR_WIDTH-1:1], 1'b0};
        if (r_mcnt != '1) r_mcnt <= r_mcnt + 1'b1;
      end
      // Counter holds FLUSH_CYCLES-1 on entry so FLUSH spans FLUSH_CYCLES cycles
      if (w_handshake)     r_fcnt <= c_FLUSH_LOAD;
      else if (w_fcnt_dec) r_fcnt <= r_fcnt - 1'b1;
    end
  end

  assign redirect_valid = (r_state == S_REDIRECT);
  assign flush          = (r_state != S_IDLE);
  assign ctrl_stall     = (r_state != S_IDLE);
  assign redirect_pc    = r_pc;
  assign branch_cnt     = r_bcnt;
  assign mispredict_cnt = r_mcnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// tb_branch_redirect_ctrl : directed bench with an event-level reference model.
// Revision: 1.0
// ============================================================================
module tb_branch_redirect_ctrl;
  localparam int AW  = 32;
  localparam int FC  = 2;
  localparam int CW  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          system_stall;
  logic          br_valid;
  logic          br_is_jump;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          redirect_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          flush;
  logic          ctrl_stall;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispredict_cnt;

  int n_total = 0;
  int n_pass  = 0;

  branch_redirect_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .system_stall(system_stall),
    .br_valid(br_valid), .br_is_jump(br_is_jump), .br_taken(br_taken),
    .br_target(br_target), .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .ctrl_stall(ctrl_stall),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  // Reference model: a pending redirect flag plus a count of flush cycles left.
  bit          m_valid = 0;
  bit          m_pending;
  int          m_flush_left;
  int          m_bcnt;
  int          m_mcnt;
  logic [AW-1:0] m_pc;

  always @(posedge clk) begin
    if (!reset) begin
      m_valid = 1; m_pending = 0; m_flush_left = 0;
      m_bcnt = 0; m_mcnt = 0; m_pc = '0;
    end else if (m_valid && !system_stall) begin
      if (m_pending) begin
        if (redirect_ready) begin
          m_pending = 0;
          m_flush_left = FC;
        end
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (br_valid) begin
        m_bcnt = (m_bcnt < MAXC) ? m_bcnt + 1 : MAXC;
        if (br_is_jump || br_taken) begin
          m_pc = br_target & ~AW'(1);
          m_mcnt = (m_mcnt < MAXC) ? m_mcnt + 1 : MAXC;
          m_pending = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_redirect_valid", redirect_valid, m_pending);
      chk("m_redirect_pc", redirect_pc, m_pc);
      chk("m_flush", flush, (m_pending || m_flush_left > 0));
      chk("m_ctrl_stall", ctrl_stall, (m_pending || m_flush_left > 0));
      chk("m_branch_cnt", branch_cnt, m_bcnt);
      chk("m_mispredict_cnt", mispredict_cnt, m_mcnt);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (ctrl_stall && n < maxc) begin
      tick();
      n++;
    end
    chk("idle_wait", ctrl_stall, 0);
  endtask

  task automatic issue(input logic jump, input logic taken, input logic [AW-1:0] tgt);
    br_valid = 1; br_is_jump = jump; br_taken = taken; br_target = tgt;
    tick();
    br_valid = 0; br_is_jump = 0; br_taken = 0;
  endtask

  initial begin
    reset = 0; system_stall = 0; br_valid = 0; br_is_jump = 0; br_taken = 0;
    br_target = '0; redirect_ready = 0;
    tick(); tick();
    reset = 1;
    chk("rst_rv", redirect_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_bcnt", branch_cnt, 0);
    chk("rst_mcnt", mispredict_cnt, 0);

    // 1: not-taken branch
    issue(0, 0, 32'h0000_0080);
    chk("nt_bcnt", branch_cnt, 1);
    chk("nt_mcnt", mispredict_cnt, 0);
    chk("nt_rv", redirect_valid, 0);
    chk("nt_flush", flush, 0);

    // 2: taken branch, fetch ready at once
    redirect_ready = 1;
    issue(0, 1, 32'h0000_0100);
    chk("tk_rv", redirect_valid, 1);
    chk("tk_pc", redirect_pc, 32'h100);
    chk("tk_flush", flush, 1);
    tick();
    chk("tk_f1_rv", redirect_valid, 0);
    chk("tk_f1_flush", flush, 1);
    tick();
    chk("tk_f2_flush", flush, 1);
    tick();
    chk("tk_idle_flush", flush, 0);
    chk("tk_mcnt", mispredict_cnt, 1);

    // 3: JALR under fetch backpressure, wrong-path pulses ignored
    redirect_ready = 0;
    issue(1, 0, 32'h0000_0203);
    for (int k = 0; k < 4; k++) begin
      chk("bp_pc", redirect_pc, 32'h202);
      chk("bp_stall", ctrl_stall, 1);
      br_valid = 1; br_is_jump = 1; br_target = 32'h0000_0999;
      tick();
    end
    br_valid = 0; br_is_jump = 0;
    redirect_ready = 1;
    chk("bp_pc5", redirect_pc, 32'h202);
    chk("bp_rv5", redirect_valid, 1);
    tick();
    chk("bp_bcnt", branch_cnt, 3);
    wait_idle(10);
    chk("bp_mcnt", mispredict_cnt, 2);

    // 4: stall while in FLUSH with the counter at 1
    issue(0, 1, 32'h0000_0040);
    tick();
    chk("st_in_flush", flush, 1);
    system_stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_hold_flush", flush, 1);
    end
    system_stall = 0;
    tick();
    chk("st_after1", flush, 1);
    tick();
    chk("st_after2", flush, 0);

    // 5: reset in REDIRECT
    redirect_ready = 0;
    issue(1, 0, 32'h0000_0500);
    chk("rr_rv_pre", redirect_valid, 1);
    reset = 0;
    tick();
    reset = 1;
    chk("rr_rv", redirect_valid, 0);
    chk("rr_flush", flush, 0);
    chk("rr_stall", ctrl_stall, 0);
    chk("rr_bcnt", branch_cnt, 0);
    chk("rr_mcnt", mispredict_cnt, 0);

    // 6: saturation of 4-bit counters after 17 taken jumps
    redirect_ready = 1;
    for (int k = 0; k < 17; k++) begin
      issue(1, 0, AW'(32'h1000 + 4 * k));
      wait_idle(10);
    end
    chk("sat_bcnt", branch_cnt, 15);
    chk("sat_mcnt", mispredict_cnt, 15);
    chk("sat_pc", redirect_pc, 32'h1040);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
